// File: rtl/alu_dispatch.sv
// Instruction-to-ALU issue controller: decodes one instruction, drives the ALU,
// captures its result and hands it back over a valid/ready handshake.
module alu_dispatch (
   input  logic        CLK,
   input  logic        RST,
   input  logic        IN_VALID,
   output logic        IN_READY,
   input  logic [31:0] INSTR,
   input  logic [31:0] RS_DATA,
   input  logic [31:0] RT_DATA,
   output logic [31:0] ALU_OP1,
   output logic [31:0] ALU_OP2,
   output logic [5:0]  ALU_OPRN,
   input  logic [31:0] ALU_OUT,
   input  logic        ALU_ZERO,
   output logic        RES_VALID,
   input  logic        RES_READY,
   output logic [31:0] RESULT,
   output logic        RES_ZERO,
   output logic [4:0]  RES_DEST,
   output logic        BRANCH_TAKEN,
   output logic        ILLEGAL
);
   localparam logic [5:0] OP_NOP = 6'h00, OP_ADD = 6'h01, OP_SUB = 6'h02, OP_MUL = 6'h03,
                          OP_SHR = 6'h04, OP_SHL = 6'h05, OP_AND = 6'h06, OP_OR  = 6'h07,
                          OP_NOR = 6'h08, OP_SLT = 6'h09;

   typedef enum logic [1:0] {S_IDLE, S_EXEC, S_DONE} state_t;
   state_t state;

   logic [5:0]  opcode, funct;
   logic [4:0]  rt, rd, shamt;
   logic [15:0] imm;
   logic [31:0] imm_sext, imm_zext;

   assign opcode   = INSTR[31:26];
   assign rt       = INSTR[20:16];
   assign rd       = INSTR[15:11];
   assign shamt    = INSTR[10:6];
   assign funct    = INSTR[5:0];
   assign imm      = INSTR[15:0];
   assign imm_sext = {{16{imm[15]}}, imm};
   assign imm_zext = {16'h0000, imm};

   // The rs index is never needed here: its value arrives already read on RS_DATA.
   logic unused_rs;
   assign unused_rs = ^INSTR[25:21];

   logic [5:0]  dec_oprn;
   logic [31:0] dec_op1, dec_op2;
   logic [4:0]  dec_dest;
   logic        dec_legal, dec_beq, dec_bne;

   always_comb begin
      dec_oprn  = OP_NOP;
      dec_op1   = RS_DATA;
      dec_op2   = RT_DATA;
      dec_dest  = 5'd0;
      dec_legal = 1'b1;
      dec_beq   = 1'b0;
      dec_bne   = 1'b0;
      case (opcode)
         6'h00: begin
            dec_dest = rd;
            case (funct)
               6'h20: dec_oprn = OP_ADD;
               6'h22: dec_oprn = OP_SUB;
               6'h2c: dec_oprn = OP_MUL;
               6'h24: dec_oprn = OP_AND;
               6'h25: dec_oprn = OP_OR;
               6'h27: dec_oprn = OP_NOR;
               6'h2a: dec_oprn = OP_SLT;
               6'h01: begin dec_oprn = OP_SHL; dec_op2 = {27'd0, shamt}; end
               6'h02: begin dec_oprn = OP_SHR; dec_op2 = {27'd0, shamt}; end
               default: dec_legal = 1'b0;
            endcase
         end
         6'h08: begin dec_oprn = OP_ADD; dec_op2 = imm_sext; dec_dest = rt; end
         6'h1d: begin dec_oprn = OP_MUL; dec_op2 = imm_sext; dec_dest = rt; end
         6'h0a: begin dec_oprn = OP_SLT; dec_op2 = imm_sext; dec_dest = rt; end
         6'h0c: begin dec_oprn = OP_AND; dec_op2 = imm_zext; dec_dest = rt; end
         6'h0d: begin dec_oprn = OP_OR;  dec_op2 = imm_zext; dec_dest = rt; end
         6'h0f: begin dec_oprn = OP_SHL; dec_op1 = imm_zext; dec_op2 = 32'd16; dec_dest = rt; end
         6'h04: begin dec_oprn = OP_SUB; dec_beq = 1'b1; end
         6'h05: begin dec_oprn = OP_SUB; dec_bne = 1'b1; end
         default: dec_legal = 1'b0;
      endcase
      // Illegal words never reach the ALU and never write back.
      if (!dec_legal) begin
         dec_oprn = OP_NOP;
         dec_op1  = 32'd0;
         dec_op2  = 32'd0;
         dec_dest = 5'd0;
         dec_beq  = 1'b0;
         dec_bne  = 1'b0;
      end
   end

   logic is_beq, is_bne;

   always_ff @(posedge CLK) begin
      if (RST) begin
         state        <= S_IDLE;
         IN_READY     <= 1'b1;
         RES_VALID    <= 1'b0;
         ALU_OP1      <= 32'd0;
         ALU_OP2      <= 32'd0;
         ALU_OPRN     <= OP_NOP;
         RESULT       <= 32'd0;
         RES_ZERO     <= 1'b0;
         RES_DEST     <= 5'd0;
         BRANCH_TAKEN <= 1'b0;
         ILLEGAL      <= 1'b0;
         is_beq       <= 1'b0;
         is_bne       <= 1'b0;
      end else begin
         case (state)
            S_IDLE: if (IN_VALID) begin
               ALU_OP1      <= dec_op1;
               ALU_OP2      <= dec_op2;
               ALU_OPRN     <= dec_oprn;
               RES_DEST     <= dec_dest;
               ILLEGAL      <= !dec_legal;
               is_beq       <= dec_beq;
               is_bne       <= dec_bne;
               RESULT       <= 32'd0;
               RES_ZERO     <= 1'b0;
               BRANCH_TAKEN <= 1'b0;
               IN_READY     <= 1'b0;
               if (dec_legal) begin
                  state <= S_EXEC;
               end else begin
                  state     <= S_DONE;
                  RES_VALID <= 1'b1;
               end
            end
            S_EXEC: begin
               RESULT       <= ALU_OUT;
               RES_ZERO     <= ALU_ZERO;
               BRANCH_TAKEN <= (is_beq && ALU_ZERO) || (is_bne && !ALU_ZERO);
               RES_VALID    <= 1'b1;
               state        <= S_DONE;
            end
            S_DONE: if (RES_READY) begin
               RES_VALID <= 1'b0;
               IN_READY  <= 1'b1;
               ALU_OPRN  <= OP_NOP;
               state     <= S_IDLE;
            end
            default: state <= S_IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_alu_dispatch.sv
// Bench for alu_dispatch: behavioural ALU plus an instruction-level reference model,
// directed cases followed by randomized instructions with random backpressure.
module tb_alu_dispatch;
   logic        CLK = 1'b0;
   logic        RST, IN_VALID, RES_READY;
   logic        IN_READY, ALU_ZERO, RES_VALID, RES_ZERO, BRANCH_TAKEN, ILLEGAL;
   logic [31:0] INSTR, RS_DATA, RT_DATA, ALU_OP1, ALU_OP2, ALU_OUT, RESULT;
   logic [5:0]  ALU_OPRN;
   logic [4:0]  RES_DEST;

   int passes = 0;
   int total  = 0;

   always #5 CLK = ~CLK;

   alu_dispatch dut (
      .CLK(CLK), .RST(RST), .IN_VALID(IN_VALID), .IN_READY(IN_READY),
      .INSTR(INSTR), .RS_DATA(RS_DATA), .RT_DATA(RT_DATA),
      .ALU_OP1(ALU_OP1), .ALU_OP2(ALU_OP2), .ALU_OPRN(ALU_OPRN),
      .ALU_OUT(ALU_OUT), .ALU_ZERO(ALU_ZERO),
      .RES_VALID(RES_VALID), .RES_READY(RES_READY), .RESULT(RESULT),
      .RES_ZERO(RES_ZERO), .RES_DEST(RES_DEST), .BRANCH_TAKEN(BRANCH_TAKEN),
      .ILLEGAL(ILLEGAL)
   );

   // Combinational ALU the block drives.
   always_comb begin
      ALU_OUT = 32'd0;
      case (ALU_OPRN)
         6'h01: ALU_OUT = ALU_OP1 + ALU_OP2;
         6'h02: ALU_OUT = ALU_OP1 - ALU_OP2;
         6'h03: ALU_OUT = ALU_OP1 * ALU_OP2;
         6'h04: ALU_OUT = ALU_OP1 >> ALU_OP2;
         6'h05: ALU_OUT = ALU_OP1 << ALU_OP2;
         6'h06: ALU_OUT = ALU_OP1 & ALU_OP2;
         6'h07: ALU_OUT = ALU_OP1 | ALU_OP2;
         6'h08: ALU_OUT = ~(ALU_OP1 | ALU_OP2);
         6'h09: ALU_OUT = ($signed(ALU_OP1) < $signed(ALU_OP2)) ? 32'd1 : 32'd0;
         default: ALU_OUT = 32'd0;
      endcase
      ALU_ZERO = (ALU_OUT == 32'd0);
   end

   typedef struct {
      bit          legal;
      logic [5:0]  oprn;
      logic [31:0] op1, op2, res;
      logic [4:0]  dest;
      bit          zero, br;
   } exp_t;

   // Instruction-level expectation: final result computed straight from the ISA meaning.
   function automatic exp_t model(input logic [31:0] ins, input logic [31:0] rs, input logic [31:0] rt);
      exp_t e;
      logic [15:0] imm;
      logic [31:0] se, ze;
      logic [4:0]  sh;
      imm = ins[15:0];
      se  = {{16{imm[15]}}, imm};
      ze  = {16'h0000, imm};
      sh  = ins[10:6];
      e.legal = 1'b1; e.op1 = rs; e.op2 = rt; e.dest = ins[20:16]; e.br = 1'b0;
      e.oprn = 6'h00; e.res = 32'd0;
      case (ins[31:26])
         6'h00: begin
            e.dest = ins[15:11];
            case (ins[5:0])
               6'h20: begin e.oprn = 6'h01; e.res = rs + rt; end
               6'h22: begin e.oprn = 6'h02; e.res = rs - rt; end
               6'h2c: begin e.oprn = 6'h03; e.res = rs * rt; end
               6'h24: begin e.oprn = 6'h06; e.res = rs & rt; end
               6'h25: begin e.oprn = 6'h07; e.res = rs | rt; end
               6'h27: begin e.oprn = 6'h08; e.res = ~(rs | rt); end
               6'h2a: begin e.oprn = 6'h09; e.res = {31'd0, $signed(rs) < $signed(rt)}; end
               6'h01: begin e.oprn = 6'h05; e.op2 = {27'd0, sh}; e.res = rs << sh; end
               6'h02: begin e.oprn = 6'h04; e.op2 = {27'd0, sh}; e.res = rs >> sh; end
               default: e.legal = 1'b0;
            endcase
         end
         6'h08: begin e.oprn = 6'h01; e.op2 = se; e.res = rs + se; end
         6'h1d: begin e.oprn = 6'h03; e.op2 = se; e.res = rs * se; end
         6'h0a: begin e.oprn = 6'h09; e.op2 = se; e.res = {31'd0, $signed(rs) < $signed(se)}; end
         6'h0c: begin e.oprn = 6'h06; e.op2 = ze; e.res = rs & ze; end
         6'h0d: begin e.oprn = 6'h07; e.op2 = ze; e.res = rs | ze; end
         6'h0f: begin e.oprn = 6'h05; e.op1 = ze; e.op2 = 32'd16; e.res = {imm, 16'h0000}; end
         6'h04: begin e.oprn = 6'h02; e.dest = 5'd0; e.res = rs - rt; e.br = (rs == rt); end
         6'h05: begin e.oprn = 6'h02; e.dest = 5'd0; e.res = rs - rt; e.br = (rs != rt); end
         default: e.legal = 1'b0;
      endcase
      if (!e.legal) begin
         e.oprn = 6'h00; e.res = 32'd0; e.dest = 5'd0;
      end
      e.zero = e.legal && (e.res == 32'd0);
      return e;
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) passes++;
      else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
   endtask

   task automatic chk_reset_state(input string tag);
      chk({tag, "_in_ready"},  IN_READY, 1);
      chk({tag, "_res_valid"}, RES_VALID, 0);
      chk({tag, "_oprn"},      ALU_OPRN, 0);
      chk({tag, "_op1"},       ALU_OP1, 0);
      chk({tag, "_op2"},       ALU_OP2, 0);
      chk({tag, "_result"},    RESULT, 0);
      chk({tag, "_flags"},     {RES_ZERO, BRANCH_TAKEN, ILLEGAL}, 0);
      chk({tag, "_dest"},      RES_DEST, 0);
   endtask

   function automatic logic [31:0] rtype(input logic [5:0] fn, input logic [4:0] rs, rt, rd, sh);
      return {6'h00, rs, rt, rd, sh, fn};
   endfunction

   function automatic logic [31:0] itype(input logic [5:0] op, input logic [4:0] rs, rt, input logic [15:0] imm);
      return {op, rs, rt, imm};
   endfunction

   // Full transaction: accept, (EXEC), DONE held for `hold` cycles, then handshake.
   task automatic issue(input string tag, input logic [31:0] ins, input logic [31:0] rs, input logic [31:0] rt,
                        input int hold, input bit stray);
      exp_t e;
      int n;
      logic [31:0] held;
      e = model(ins, rs, rt);
      n = 0;
      while (IN_READY !== 1'b1 && n < 20) begin @(negedge CLK); n++; end
      chk({tag, "_ready_wait"}, IN_READY, 1);
      INSTR = ins; RS_DATA = rs; RT_DATA = rt; IN_VALID = 1'b1;
      @(negedge CLK);
      IN_VALID = 1'b0; INSTR = $urandom; RS_DATA = $urandom; RT_DATA = $urandom;
      chk({tag, "_oprn"}, ALU_OPRN, e.oprn);
      chk({tag, "_busy"}, IN_READY, 0);
      if (e.legal) begin
         chk({tag, "_op1"}, ALU_OP1, e.op1);
         chk({tag, "_op2"}, ALU_OP2, e.op2);
         chk({tag, "_exec_valid"}, RES_VALID, 0);
         @(negedge CLK);
         chk({tag, "_oprn_hold"}, ALU_OPRN, e.oprn);
      end
      chk({tag, "_res_valid"}, RES_VALID, 1);
      chk({tag, "_result"},    RESULT, e.res);
      chk({tag, "_zero"},      RES_ZERO, e.zero);
      chk({tag, "_dest"},      RES_DEST, e.dest);
      chk({tag, "_branch"},    BRANCH_TAKEN, e.br);
      chk({tag, "_illegal"},   ILLEGAL, !e.legal);
      held = RESULT;
      for (int i = 0; i < hold; i++) begin
         if (stray) begin IN_VALID = 1'b1; INSTR = $urandom; end
         @(negedge CLK);
         chk({tag, "_bp_valid"},  RES_VALID, 1);
         chk({tag, "_bp_ready"},  IN_READY, 0);
         chk({tag, "_bp_result"}, RESULT, held);
         chk({tag, "_bp_oprn"},   ALU_OPRN, e.oprn);
      end
      IN_VALID = 1'b0; RES_READY = 1'b1;
      @(negedge CLK);
      RES_READY = 1'b0;
      chk({tag, "_post_valid"}, RES_VALID, 0);
      chk({tag, "_post_ready"}, IN_READY, 1);
      chk({tag, "_post_oprn"},  ALU_OPRN, 0);
   endtask

   initial begin
      logic [5:0]  functs [9] = '{6'h20, 6'h22, 6'h2c, 6'h24, 6'h25, 6'h27, 6'h2a, 6'h01, 6'h02};
      logic [5:0]  opcs   [8] = '{6'h08, 6'h1d, 6'h0a, 6'h0c, 6'h0d, 6'h0f, 6'h04, 6'h05};
      logic [31:0] ins, a, b;
      int sel;

      // Reset with a valid instruction present: reset wins.
      RST = 1'b1; IN_VALID = 1'b1; RES_READY = 1'b0;
      INSTR = rtype(6'h20, 5'd1, 5'd2, 5'd3, 5'd0); RS_DATA = 32'd5; RT_DATA = 32'd7;
      @(negedge CLK); @(negedge CLK);
      chk_reset_state("reset");
      RST = 1'b0; IN_VALID = 1'b0;
      @(negedge CLK);

      issue("add",   rtype(6'h20, 5'd1, 5'd2, 5'd3, 5'd0), 32'd5, 32'd7, 0, 0);
      issue("addi",  itype(6'h08, 5'd1, 5'd4, 16'hffff), 32'd1, 32'd0, 0, 0);
      issue("ori",   itype(6'h0d, 5'd1, 5'd5, 16'h8000), 32'h0000_0001, 32'd0, 0, 0);
      issue("lui",   itype(6'h0f, 5'd0, 5'd6, 16'h1234), 32'hdead_beef, 32'd0, 0, 0);
      issue("beq",   itype(6'h04, 5'd1, 5'd2, 16'h0010), 32'd9, 32'd9, 0, 0);
      issue("bne",   itype(6'h05, 5'd1, 5'd2, 16'h0010), 32'd9, 32'd9, 0, 0);
      issue("sll_r0", rtype(6'h01, 5'd1, 5'd2, 5'd0, 5'd4), 32'h0000_00f1, 32'd0, 0, 0);
      issue("slti",  itype(6'h0a, 5'd1, 5'd7, 16'h8000), 32'hffff_0000, 32'd0, 0, 0);
      issue("illegal", {6'h3f, 26'h155_5555}, 32'd3, 32'd4, 0, 0);
      issue("bad_funct", rtype(6'h3e, 5'd1, 5'd2, 5'd9, 5'd0), 32'd3, 32'd4, 1, 0);
      issue("bp",    rtype(6'h22, 5'd1, 5'd2, 5'd8, 5'd0), 32'd100, 32'd58, 5, 1);
      issue("bp_next", rtype(6'h2c, 5'd1, 5'd2, 5'd9, 5'd0), 32'd6, 32'hffff_fffd, 0, 0);

      // Reset while a result is waiting in DONE discards it.
      INSTR = rtype(6'h20, 5'd1, 5'd2, 5'd3, 5'd0); RS_DATA = 32'd11; RT_DATA = 32'd22; IN_VALID = 1'b1;
      @(negedge CLK); IN_VALID = 1'b0;
      @(negedge CLK);
      chk("abort_pre_valid", RES_VALID, 1);
      chk("abort_pre_result", RESULT, 32'd33);
      RST = 1'b1; IN_VALID = 1'b1; RES_READY = 1'b1;
      @(negedge CLK);
      chk_reset_state("abort");
      RST = 1'b0; IN_VALID = 1'b0; RES_READY = 1'b0;
      @(negedge CLK);

      for (int k = 0; k < 60; k++) begin
         sel = $urandom_range(0, 18);
         if (sel < 9)
            ins = rtype(functs[sel], 5'($urandom), 5'($urandom), 5'($urandom), 5'($urandom));
         else if (sel < 17)
            ins = itype(opcs[sel-9], 5'($urandom), 5'($urandom), 16'($urandom));
         else
            ins = $urandom;
         a = $urandom;
         b = ($urandom_range(0, 3) == 0) ? a : $urandom;
         issue($sformatf("rand%0d", k), ins, a, b, $urandom_range(0, 3), 1'($urandom));
      end

      $display("%0d/%0d checks passed", passes, total);
      $finish;
   end
endmodule

// File: doc/alu_dispatch.md
# alu_dispatch

Instruction-to-ALU issue controller for the 32-bit datapath: accepts one instruction word plus its source-register values over a valid/ready handshake and decodes it into an ALU operation code and operands. It drives the combinational ALU, captures the ALU result and zero flag, and returns them with the destination register index and branch outcome over a second valid/ready handshake. It sits between register read and writeback; it is the driving side of the ALU `OP1`/`OP2`/`OPRN` → `OUT`/`ZERO` interface.

## Interface
- No parameters; data width fixed at 32, ALU opcode width fixed at 6.
- CLK  in  1  clock; all state changes on rising edge.
- RST  in  1  reset; synchronous, active-high.
- IN_VALID  in  1  INSTR/RS_DATA/RT_DATA valid.
- IN_READY  out  1  block can accept an instruction.
- INSTR  in  32  instruction word: [31:26] opcode, [25:21] rs, [20:16] rt, [15:11] rd, [10:6] shamt, [5:0] funct, [15:0] imm.
- RS_DATA  in  32  value of register rs.
- RT_DATA  in  32  value of register rt.
- ALU_OP1  out  32  ALU operand 1 (registered).
- ALU_OP2  out  32  ALU operand 2 (registered).
- ALU_OPRN  out  6  ALU operation code (registered).
- ALU_OUT  in  32  ALU result.
- ALU_ZERO  in  1  ALU zero flag (ALU_OUT == 0).
- RES_VALID  out  1  result outputs valid.
- RES_READY  in  1  consumer accepts result.
- RESULT  out  32  captured ALU result.
- RES_ZERO  out  1  captured zero flag.
- RES_DEST  out  5  destination register index; 0 = no writeback.
- BRANCH_TAKEN  out  1  branch condition true (beq/bne only).
- ILLEGAL  out  1  undecodable instruction.

## Operation
- ALU codes: add 0x01, sub 0x02, mul 0x03, shr 0x04, shl 0x05, and 0x06, or 0x07, nor 0x08, slt 0x09; 0x00 = idle/no-op.
- R-type (opcode 0x00), OP1=RS_DATA, OP2=RT_DATA, dest=rd. funct: 0x20 add, 0x22 sub, 0x2c mul, 0x24 and, 0x25 or, 0x27 nor, 0x2a slt. Shifts 0x01 sll→shl and 0x02 srl→shr use OP2 = {27'b0, shamt}.
- I-type, OP1=RS_DATA, dest=rt. 0x08 addi→add, 0x1d muli→mul, 0x0a slti→slt, all with sign-extended imm. 0x0c andi→and and 0x0d ori→or, with zero-extended imm. 0x0f lui→shl with OP1={16'b0,imm}, OP2=16.
- Branch: 0x04 beq and 0x05 bne→sub with OP1=RS_DATA, OP2=RT_DATA, dest=0. BRANCH_TAKEN = ALU_ZERO (beq) or !ALU_ZERO (bne), captured with the result. BRANCH_TAKEN=0 for all other instructions.
- Any other opcode or funct: ILLEGAL=1, RESULT=0, RES_ZERO=0, RES_DEST=0, BRANCH_TAKEN=0. ALU not issued (ALU_OPRN stays 0x00).
- RES_DEST=0 whenever the decoded destination field is 0; writes to r0 are suppressed.
- FSM states:
  - IDLE: IN_READY=1. On IN_VALID, latch the decoded OP1/OP2/OPRN and go to EXEC; for an illegal instruction, go directly to DONE.
  - EXEC: ALU evaluates. Next edge captures ALU_OUT/ALU_ZERO into RESULT/RES_ZERO, sets BRANCH_TAKEN, and goes to DONE.
  - DONE: RES_VALID=1; all result outputs held stable. On RES_READY, go to IDLE and return ALU_OPRN to 0x00.
- ALU_OP1/ALU_OP2/ALU_OPRN are held constant throughout EXEC and DONE.

## Timing
- Reset: state IDLE. IN_READY=1, RES_VALID=0, ALU_OP1=ALU_OP2=0, ALU_OPRN=0x00, RESULT=0, RES_ZERO=0, RES_DEST=0, BRANCH_TAKEN=0, ILLEGAL=0.
- Accept at edge E0 (IN_VALID & IN_READY). EXEC runs during cycle E0→E1. RES_VALID=1 from E1.
- Result handshake completes at the first edge with RES_VALID & RES_READY. IN_READY rises after that edge.
- Minimum issue interval: 3 cycles with RES_READY held high. Illegal instructions: 2 cycles.
- IN_READY=0 in EXEC and DONE. IN_VALID there is ignored and nothing is latched.
- RES_READY outside DONE has no effect.
- RST during EXEC or DONE: abort; all outputs return to reset values at that edge. The in-flight result is discarded.
- RST has priority over every handshake in the same cycle.

## Test plan
- Reset: assert RST with IN_VALID=1 → after the edge, IN_READY=1, RES_VALID=0, ALU_OPRN=0x00, all outputs 0.
- add (R, funct 0x20, rd=3) with RS=5, RT=7 → ALU_OPRN=0x01, RESULT=12, RES_DEST=3, RES_VALID one edge after EXEC.
- addi -1 with RS=1 → OP2=0xFFFFFFFF, RESULT=0, RES_ZERO=1. ori 0x8000 → OP2=0x00008000. lui 0x1234 → RESULT=0x12340000.
- beq with RS=RT=9 → BRANCH_TAKEN=1, RES_DEST=0. bne with the same operands → BRANCH_TAKEN=0.
- Backpressure: hold RES_READY=0 for 5 cycles → RESULT stable, IN_READY=0, a second IN_VALID is not accepted. Release → next instruction accepted the cycle after.
- Opcode 0x3F → ILLEGAL=1, RES_VALID two edges... one edge after accept, ALU_OPRN=0x00. Separately, RST in DONE → outputs return to reset values immediately.
